// File: rtl/instr_fetch_if.sv
// Instruction-memory request/acknowledge port of the fetch stage.
//
// Handshake: the master raises imem_req with imem_addr; once raised,
// imem_req stays 1 and imem_addr stays stable until the slave returns
// imem_ack=1 together with imem_rdata. The ack may come in the same cycle
// the request is first raised. imem_rdata is meaningful only while imem_ack=1.
interface instr_fetch_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the fetch PC, drives the instruction-memory
// port, and feeds IF/ID with one instruction or a NOP bubble per cycle.
// Stalls are absorbed by a one-entry skid buffer; redirects issued while a
// request is outstanding go through DROP so the stale response is discarded.
module instr_fetch #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'hD503201F
) (
    input  logic                 clk,
    input  logic                 reset,       // asynchronous, active-low
    input  logic                 stall,
    input  logic                 br_taken,
    input  logic [63:0]          br_target,
    instr_fetch_if.master        imem,
    output logic                 if_valid,
    output logic [63:0]          if_pc,
    output logic [31:0]          if_instr,
    output logic                 fsm_state_o  // 0 = RUN, 1 = DROP
);

    typedef enum logic {
        RUN  = 1'b0,
        DROP = 1'b1
    } state_t;

    state_t      state_q;
    logic [63:0] pc_q;
    logic [63:0] req_addr_q;
    logic        pending_q;
    logic        skid_v_q;
    logic [63:0] skid_pc_q;
    logic [31:0] skid_instr_q;
    logic        if_valid_q;
    logic [63:0] if_pc_q;
    logic [31:0] if_instr_q;

    logic        core_req;
    logic [63:0] addr_w;
    logic        ack_fire;
    logic        ack_run;

    // Request logic: an outstanding request always continues; a new one starts
    // only in RUN with room to hold its data (skid empty).
    assign core_req = pending_q | ((state_q == RUN) & ~skid_v_q);
    assign addr_w   = pending_q ? req_addr_q : pc_q;
    assign ack_fire = core_req & imem.imem_ack;
    assign ack_run  = ack_fire & (state_q == RUN);

    // Port outputs; the request is forced low while reset is held.
    assign imem.imem_req  = reset & core_req;
    assign imem.imem_addr = addr_w;

    assign if_valid    = if_valid_q;
    assign if_pc       = if_pc_q;
    assign if_instr    = if_instr_q;
    assign fsm_state_o = logic'(state_q);

    // Fetch FSM, request tracking, skid buffer and IF/ID-facing output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            pending_q    <= 1'b0;
            skid_v_q     <= 1'b0;
            skid_pc_q    <= 64'h0;
            skid_instr_q <= 32'h0;
            if_valid_q   <= 1'b0;
            if_pc_q      <= 64'h0;
            if_instr_q   <= NOP_INSTR;
        end else begin
            pending_q  <= core_req & ~imem.imem_ack;
            req_addr_q <= addr_w;

            if (br_taken) begin
                // Redirect wins over everything, including stall.
                pc_q       <= br_target & ~64'h3;
                skid_v_q   <= 1'b0;
                if_valid_q <= 1'b0;
                if_instr_q <= NOP_INSTR;
                // An unacked request must still complete; its data is dropped.
                state_q    <= (core_req & ~imem.imem_ack) ? DROP : RUN;
            end else begin
                if ((state_q == DROP) && ack_fire) begin
                    state_q <= RUN;
                end
                if (ack_run) begin
                    pc_q <= addr_w + 64'd4;
                end
                if (stall) begin
                    // Outputs hold; a fresh response parks in the skid entry.
                    if (ack_run) begin
                        skid_v_q     <= 1'b1;
                        skid_pc_q    <= addr_w;
                        skid_instr_q <= imem.imem_rdata;
                    end
                end else if (skid_v_q) begin
                    if_valid_q <= 1'b1;
                    if_pc_q    <= skid_pc_q;
                    if_instr_q <= skid_instr_q;
                    skid_v_q   <= 1'b0;
                end else if (ack_run) begin
                    if_valid_q <= 1'b1;
                    if_pc_q    <= addr_w;
                    if_instr_q <= imem.imem_rdata;
                end else begin
                    if_valid_q <= 1'b0;
                    if_instr_q <= NOP_INSTR;
                end
            end
        end
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage of the pipelined ARM64 core. It sits directly upstream of the IF/ID pipeline register. It owns the fetch PC and drives a request/acknowledge instruction-memory port. It presents one instruction per cycle, or a NOP bubble, on `if_pc`/`if_instr`/`if_valid`, which feed the IF/ID `PC_in`/`instr_in`. Branch redirects and hazard stalls from later stages are absorbed with a one-entry skid buffer and a discard state for in-flight requests.

## Interface
- `RESET_PC`, default 64'h0: fetch address after reset; bits [1:0] must be 0.
- `NOP_INSTR`, default 32'hD503201F: ARM64 NOP emitted for bubbles.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  one clock; reset is asynchronous and active-low (`reset`=0 resets the block).
- `stall`  in  1  hazard stall; when 1, the `if_*` outputs hold.
- `br_taken`  in  1  redirect request from the branch-resolution stage.
- `br_target`  in  64  redirect address.
- `imem_req`  out  1  memory request valid.
- `imem_addr`  out  64  request address, word-aligned.
- `imem_ack`  in  1  memory response valid; may arrive in the same cycle the request is first raised.
- `imem_rdata`  in  32  instruction; valid only when `imem_ack`=1.
- `if_valid`  out  1  `if_instr` is a real instruction.
- `if_pc`  out  64  PC of `if_instr`.
- `if_instr`  out  32  instruction to IF/ID.

## Operation
- State registers:
  - `pc`: next address to request.
  - `req_addr`: the address on `imem_addr`.
  - `pending`: request raised but not yet acked.
  - skid entry: valid, pc, instr.
  - FSM state: RUN or DROP.
  - output registers: `if_valid`, `if_pc`, `if_instr`.
- Request protocol: once `imem_req`=1, it stays 1 and `imem_addr` stays stable until the cycle `imem_ack`=1, regardless of stall or redirect.
- `imem_req` = `pending` OR (state RUN AND skid empty). When a new request starts, `req_addr` = `pc`.
- RUN, ack received:
  - `pc` <= `req_addr`+4, mod 2^64.
  - Data routing when `stall`=0: data goes to the output registers (`if_valid`=1, `if_pc`=`req_addr`).
  - Data routing when `stall`=1: data goes to the skid entry. If the skid entry is already full, no request was issued, so this case cannot occur.
- Output register update when `stall`=0, in priority order:
  1. Skid full: load skid, clear skid.
  2. Ack in RUN: load the ack data.
  3. Otherwise: bubble (`if_valid`=0, `if_instr`=`NOP_INSTR`, `if_pc` unchanged).
- Output register update when `stall`=1: the outputs hold. The skid fills only as described above.
- `br_taken`=1 has highest priority and applies even when `stall`=1:
  - `pc` <= {`br_target`[63:2], 2'b00}; low bits are silently dropped.
  - Skid cleared; output registers become a bubble.
  - If a request is outstanding and `imem_ack`=0 this cycle, go to DROP.
  - If `imem_ack`=1 this cycle, that data is discarded and the state stays RUN.
- DROP:
  - `imem_req` stays 1 on the old `req_addr`.
  - On ack, the data is discarded and the state returns to RUN. The next request uses the redirected `pc`.
  - Another `br_taken` in DROP updates `pc` only; the state stays DROP.
- Every cycle without a valid instruction to deliver produces a bubble. IF/ID is always written with legal content.

## Timing
- Reset values while `reset`=0, applied immediately (asynchronous):
  - `pc`=`RESET_PC`; state RUN; `pending`=0; skid empty.
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `if_valid`=0, `if_pc`=0, `if_instr`=`NOP_INSTR`.
- First request: `imem_req` rises in the first cycle after `reset` deasserts.
- Latency: data acked in cycle N appears on `if_*` after edge N+1 when not stalled.
- Throughput: with a zero-wait memory, one instruction per cycle.
- Reset mid-operation (including in DROP or with the skid full) abandons all state. The memory is expected to be reset with the core.
- A redirect takes effect at the next edge; the first redirected instruction appears on `if_*` no earlier than two edges later.

## Test plan
- Reset, then zero-wait ack, `stall`=0 → `imem_addr` = 0, 4, 8, …; `if_valid`=1 with `if_pc` = 0, 4, 8 on consecutive cycles; `if_instr` matches memory.
- Ack delayed 2 cycles per request → `imem_req` held with `imem_addr` stable until ack; `if_*` alternates real instruction and NOP bubbles with `if_valid`=0.
- `stall`=1 for 3 cycles while ack for 0x8 arrives → `if_*` frozen on PC 0x4; skid holds 0x8; `imem_req`=0 while skid full. On release: `if_pc` = 0x8, 0xC with no loss or duplication.
- `br_taken`, `br_target`=0x1000 while request 0x8 is pending un-acked → DROP; `imem_addr` stays 0x8 until ack; data discarded; next request 0x1000; first valid `if_pc`=0x1000.
- `br_taken` with `br_target`=0x1002 in the same cycle as an ack, with `stall`=1 → acked data discarded; output becomes a bubble; next request 0x1000.
- `RESET_PC`=64'hFFFF_FFFF_FFFF_FFFC → second request address 0x0. Assert `reset` in DROP → all outputs reach reset values without waiting for a clock edge.
